sequential_divider: RTL and testbench
=====================================

Name: sequential_divider

Overview:
- Multi-cycle integer divider. It is the inverse operation of the ALU's combinational multiplier.
- Computes quotient and remainder of x / y using a restoring shift-subtract algorithm, one quotient bit per clock.
- Supports signed and unsigned operation. Signed division truncates toward zero.
- Sits beside the multiplier in the integer ALU. Uses the same negative/zero/overflow/cout flag set, and adds a start/busy/done handshake.

Parameters:
- WIDTH, 16, operand width in bits. Quotient and remainder are also WIDTH bits. Legal values are 4 or greater.

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a new division; sampled only in IDLE
- x  input  WIDTH  dividend, sampled on the accepted start edge
- y  input  WIDTH  divisor, sampled on the accepted start edge
- signed_unsigned  input  1  1 = two's-complement operation, 0 = unsigned; sampled with start
- q  output  WIDTH  quotient, registered
- rem  output  WIDTH  remainder, registered
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse when q/rem/flags become valid
- negative  output  1  signed_unsigned_latched & q[WIDTH-1]
- zero  output  1  1 when q == 0
- overflow  output  1  divide-by-zero, or signed (most-negative / -1)
- cout  output  1  tied 0

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - q, rem, busy, done, negative, zero, overflow and the latched mode bit all clear to 0.
  - Takes effect immediately, including mid-operation; any division in flight is abandoned and no done is issued.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - A start=1 on a rising edge latches x, y and signed_unsigned.
  - Signed operands are converted to magnitudes; unsigned operands pass through.
  - Iteration counter is loaded with WIDTH; the partial remainder is cleared.
  - If y == 0, go to FIX with the divide-by-zero flag set; otherwise go to CALC.
- CALC, once per cycle:
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor magnitude from the upper WIDTH+1 bits.
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - Decrement the counter. When it reaches 1 on this edge, go to FIX. This gives exactly WIDTH CALC cycles.
- FIX, one cycle; registers q, rem and the flags:
  - Quotient sign = sign_x ^ sign_y (signed mode only). Remainder sign = sign_x (signed mode only).
  - Negation is two's complement at WIDTH bits.
  - Divide-by-zero: q = all ones, rem = x (raw), overflow = 1.
  - Signed x = 100...0 with y = all ones: q = x, rem = 0, overflow = 1.
  - All other cases: overflow = 0.
  - zero is computed from the final q.
- DONE, one cycle:
  - done = 1, busy = 0, then return to IDLE.
  - A start during DONE is ignored; start is accepted only in IDLE.
- busy is high in CALC and FIX.
- Latency:
  - Normal case: done is high in the cycle after rising edge WIDTH+2, counted from the start edge as edge 0.
  - Divide-by-zero: done follows edge 2.
- Throughput: with start held high continuously, a new division is accepted at most every WIDTH+3 cycles.
- start asserted while busy or done is high is ignored; no queuing.
- q, rem and the flags hold their values from FIX until the next FIX or reset. Input changes after the start edge have no effect.
- The signed magnitude of the most-negative operand is represented in WIDTH bits as unsigned 100...0. Internal magnitudes are unsigned, so no extra bit is needed.

Test Plan (WIDTH=16):
- Unsigned 100/7 (x=0x0064, y=0x0007), start at edge 0 -> done high after edge 18; q=0x000E, rem=0x0002; negative=0, zero=0, overflow=0.
- Signed -100/7 (x=0xFF9C, y=0x0007) -> q=0xFFF2 (-14), rem=0xFFFE (-2), negative=1. Repeat with x=0x0064, y=0xFFF9 (100/-7) -> q=0xFFF2, rem=0x0002.
- y=0, x=0x1234, either mode -> done after edge 2; q=0xFFFF, rem=0x1234, overflow=1.
- Signed 0x8000/0xFFFF -> q=0x8000, rem=0, overflow=1, negative=1. Unsigned 0x8000/0xFFFF -> q=0, rem=0x8000, zero=1, overflow=0.
- Start pulsed again at edges 3 and 10 during a 100/7 run -> ignored; the single done and result match the first test.
- Drop rst_n at edge 8 of a division -> busy=0, q=0, rem=0 immediately; no done. A new start after reset completes normally.

Source files
------------

// File: rtl/sequential_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, signed or unsigned,
// with start/busy/done handshake and the ALU negative/zero/overflow/cout flags.
module sequential_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             signed_unsigned,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rem,
    output logic             busy,
    output logic             done,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] prem;      // partial remainder (magnitude)
    logic [WIDTH-1:0] dvd;       // dividend magnitude, quotient bits shift in at LSB
    logic [WIDTH-1:0] mag_y;
    logic [WIDTH-1:0] x_raw;
    logic             mode;
    logic             sign_x;
    logic             sign_y;
    logic             dbz;
    logic             ovf_min;

    logic [WIDTH-1:0] mag_x_in;
    logic [WIDTH-1:0] mag_y_in;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic             ovf_fix;

    assign cout = 1'b0;

    // Operand magnitudes, trial subtraction and final sign/special-case fixup
    always_comb begin
        mag_x_in = (signed_unsigned && x[WIDTH-1]) ? -x : x;
        mag_y_in = (signed_unsigned && y[WIDTH-1]) ? -y : y;
        shifted  = {prem, dvd[WIDTH-1]};
        diff     = shifted - {1'b0, mag_y};
        q_fix    = (mode && (sign_x ^ sign_y)) ? -dvd : dvd;
        r_fix    = (mode && sign_x) ? -prem : prem;
        ovf_fix  = 1'b0;
        if (dbz) begin
            q_fix   = '1;
            r_fix   = x_raw;
            ovf_fix = 1'b1;
        end else if (ovf_min) begin
            q_fix   = x_raw;
            r_fix   = '0;
            ovf_fix = 1'b1;
        end
    end

    // Control FSM with datapath and registered results/flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            prem     <= '0;
            dvd      <= '0;
            mag_y    <= '0;
            x_raw    <= '0;
            mode     <= 1'b0;
            sign_x   <= 1'b0;
            sign_y   <= 1'b0;
            dbz      <= 1'b0;
            ovf_min  <= 1'b0;
            q        <= '0;
            rem      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            negative <= 1'b0;
            zero     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        x_raw   <= x;
                        mode    <= signed_unsigned;
                        sign_x  <= signed_unsigned & x[WIDTH-1];
                        sign_y  <= signed_unsigned & y[WIDTH-1];
                        dvd     <= mag_x_in;
                        mag_y   <= mag_y_in;
                        prem    <= '0;
                        cnt     <= CW'(WIDTH);
                        dbz     <= (y == '0);
                        ovf_min <= signed_unsigned && (x == MIN_NEG) && (y == '1);
                        busy    <= 1'b1;
                        state   <= (y == '0) ? FIX : CALC;
                    end
                end
                CALC: begin
                    prem <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                    dvd  <= {dvd[WIDTH-2:0], ~diff[WIDTH]};
                    cnt  <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    q        <= q_fix;
                    rem      <= r_fix;
                    overflow <= ovf_fix;
                    negative <= mode & q_fix[WIDTH-1];
                    zero     <= (q_fix == '0);
                    state    <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sequential_divider.sv
// Directed self-checking bench for sequential_divider at WIDTH=16.
module tb_sequential_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] x;
    logic [15:0] y;
    logic        signed_unsigned;
    logic [15:0] q;
    logic [15:0] rem;
    logic        busy;
    logic        done;
    logic        negative;
    logic        zero;
    logic        overflow;
    logic        cout;

    int n_cmp = 0;
    int n_err = 0;

    sequential_divider #(.WIDTH(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .x(x),
        .y(y),
        .signed_unsigned(signed_unsigned),
        .q(q),
        .rem(rem),
        .busy(busy),
        .done(done),
        .negative(negative),
        .zero(zero),
        .overflow(overflow),
        .cout(cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one start (accepted at edge 0) and watch 40 edges for done
    task automatic do_div(input logic [15:0] a, input logic [15:0] b, input logic s,
                          output int dedge, output int ndone);
        @(negedge clk);
        x = a; y = b; signed_unsigned = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dedge = -1;
        ndone = 0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                if (dedge < 0) dedge = e;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; x = '0; y = '0; signed_unsigned = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({q, rem, busy, done, negative, zero, overflow, cout} !== 38'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got q=%h rem=%h busy=%b done=%b n=%b z=%b o=%b c=%b, want all 0",
                     q, rem, busy, done, negative, zero, overflow, cout);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_unsigned();
        int de, nd;
        do_div(16'h0064, 16'h0007, 1'b0, de, nd);
        n_cmp++; if (de !== 18) begin n_err++; $display("FAIL u100_7_latency: got %0d want 18", de); end
        n_cmp++; if (nd !== 1) begin n_err++; $display("FAIL u100_7_done_count: got %0d want 1", nd); end
        n_cmp++; if (q !== 16'h000E) begin n_err++; $display("FAIL u100_7_q: got %h want 000e", q); end
        n_cmp++; if (rem !== 16'h0002) begin n_err++; $display("FAIL u100_7_rem: got %h want 0002", rem); end
        n_cmp++;
        if ({negative, zero, overflow, cout, busy} !== 5'b00000) begin
            n_err++; $display("FAIL u100_7_flags: got nzocb=%b want 00000", {negative, zero, overflow, cout, busy});
        end
    endtask

    task automatic test_signed();
        int de, nd;
        do_div(16'hFF9C, 16'h0007, 1'b1, de, nd);
        n_cmp++; if (de !== 18) begin n_err++; $display("FAIL sm100_7_latency: got %0d want 18", de); end
        n_cmp++; if (q !== 16'hFFF2) begin n_err++; $display("FAIL sm100_7_q: got %h want fff2", q); end
        n_cmp++; if (rem !== 16'hFFFE) begin n_err++; $display("FAIL sm100_7_rem: got %h want fffe", rem); end
        n_cmp++;
        if ({negative, zero, overflow} !== 3'b100) begin
            n_err++; $display("FAIL sm100_7_flags: got nzo=%b want 100", {negative, zero, overflow});
        end
        do_div(16'h0064, 16'hFFF9, 1'b1, de, nd);
        n_cmp++; if (q !== 16'hFFF2) begin n_err++; $display("FAIL s100_m7_q: got %h want fff2", q); end
        n_cmp++; if (rem !== 16'h0002) begin n_err++; $display("FAIL s100_m7_rem: got %h want 0002", rem); end
        n_cmp++; if (negative !== 1'b1) begin n_err++; $display("FAIL s100_m7_neg: got %b want 1", negative); end
    endtask

    task automatic test_div_by_zero();
        int de, nd;
        do_div(16'h1234, 16'h0000, 1'b0, de, nd);
        n_cmp++; if (de !== 2) begin n_err++; $display("FAIL udbz_latency: got %0d want 2", de); end
        n_cmp++; if (q !== 16'hFFFF) begin n_err++; $display("FAIL udbz_q: got %h want ffff", q); end
        n_cmp++; if (rem !== 16'h1234) begin n_err++; $display("FAIL udbz_rem: got %h want 1234", rem); end
        n_cmp++;
        if ({negative, zero, overflow} !== 3'b001) begin
            n_err++; $display("FAIL udbz_flags: got nzo=%b want 001", {negative, zero, overflow});
        end
        do_div(16'h1234, 16'h0000, 1'b1, de, nd);
        n_cmp++; if (de !== 2) begin n_err++; $display("FAIL sdbz_latency: got %0d want 2", de); end
        n_cmp++; if (q !== 16'hFFFF) begin n_err++; $display("FAIL sdbz_q: got %h want ffff", q); end
        n_cmp++; if (rem !== 16'h1234) begin n_err++; $display("FAIL sdbz_rem: got %h want 1234", rem); end
        n_cmp++;
        if ({negative, zero, overflow} !== 3'b101) begin
            n_err++; $display("FAIL sdbz_flags: got nzo=%b want 101", {negative, zero, overflow});
        end
    endtask

    task automatic test_overflow();
        int de, nd;
        do_div(16'h8000, 16'hFFFF, 1'b1, de, nd);
        n_cmp++; if (de !== 18) begin n_err++; $display("FAIL sovf_latency: got %0d want 18", de); end
        n_cmp++; if (q !== 16'h8000) begin n_err++; $display("FAIL sovf_q: got %h want 8000", q); end
        n_cmp++; if (rem !== 16'h0000) begin n_err++; $display("FAIL sovf_rem: got %h want 0000", rem); end
        n_cmp++;
        if ({negative, zero, overflow} !== 3'b101) begin
            n_err++; $display("FAIL sovf_flags: got nzo=%b want 101", {negative, zero, overflow});
        end
        do_div(16'h8000, 16'hFFFF, 1'b0, de, nd);
        n_cmp++; if (q !== 16'h0000) begin n_err++; $display("FAIL u8000_q: got %h want 0000", q); end
        n_cmp++; if (rem !== 16'h8000) begin n_err++; $display("FAIL u8000_rem: got %h want 8000", rem); end
        n_cmp++;
        if ({negative, zero, overflow} !== 3'b010) begin
            n_err++; $display("FAIL u8000_flags: got nzo=%b want 010", {negative, zero, overflow});
        end
    endtask

    task automatic test_ignored_start();
        int de, nd;
        @(negedge clk);
        x = 16'h0064; y = 16'h0007; signed_unsigned = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        de = -1; nd = 0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk); #1;
            if (done) begin
                nd++;
                if (de < 0) de = e;
            end
            if (e == 2 || e == 9) begin
                x = 16'h0FFF; y = 16'h0003; signed_unsigned = 1'b1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        n_cmp++; if (de !== 18) begin n_err++; $display("FAIL ign_latency: got %0d want 18", de); end
        n_cmp++; if (nd !== 1) begin n_err++; $display("FAIL ign_done_count: got %0d want 1", nd); end
        n_cmp++; if (q !== 16'h000E) begin n_err++; $display("FAIL ign_q: got %h want 000e", q); end
        n_cmp++; if (rem !== 16'h0002) begin n_err++; $display("FAIL ign_rem: got %h want 0002", rem); end
    endtask

    task automatic test_back_to_back();
        int d1, d2;
        logic [15:0] q1, r1;
        d1 = -1; d2 = -1; q1 = '0; r1 = '0;
        @(negedge clk);
        x = 16'h0064; y = 16'h0007; signed_unsigned = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        x = 16'h00C8;   // 200: only the second accepted start should see this
        for (int e = 1; e <= 45; e++) begin
            @(posedge clk); #1;
            if (done) begin
                if (d1 < 0) begin
                    d1 = e; q1 = q; r1 = rem;
                end else if (d2 < 0) begin
                    d2 = e;
                end
            end
            if (e == 37) start = 1'b0;
        end
        start = 1'b0;
        n_cmp++; if (d1 !== 18) begin n_err++; $display("FAIL b2b_first_done: got %0d want 18", d1); end
        n_cmp++; if (d2 !== 37) begin n_err++; $display("FAIL b2b_second_done: got %0d want 37", d2); end
        n_cmp++; if ({q1, r1} !== {16'h000E, 16'h0002}) begin
            n_err++; $display("FAIL b2b_first_result: got q=%h rem=%h want 000e 0002", q1, r1);
        end
        n_cmp++; if ({q, rem} !== {16'h001C, 16'h0004}) begin
            n_err++; $display("FAIL b2b_second_result: got q=%h rem=%h want 001c 0004", q, rem);
        end
    endtask

    task automatic test_reset_mid();
        int de, nd;
        @(negedge clk);
        x = 16'h0064; y = 16'h0007; signed_unsigned = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        n_cmp++; if ({q, rem} !== 32'd0) begin
            n_err++; $display("FAIL rst_mid_result: got q=%h rem=%h want 0000 0000", q, rem);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        nd = 0;
        for (int e = 0; e < 25; e++) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        n_cmp++; if (nd !== 0) begin n_err++; $display("FAIL rst_mid_no_done: got %0d want 0", nd); end
        do_div(16'd1000, 16'd33, 1'b0, de, nd);
        n_cmp++; if (de !== 18) begin n_err++; $display("FAIL post_rst_latency: got %0d want 18", de); end
        n_cmp++; if ({q, rem} !== {16'h001E, 16'h000A}) begin
            n_err++; $display("FAIL post_rst_result: got q=%h rem=%h want 001e 000a", q, rem);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_by_zero();
        test_overflow();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
